trdb_cfg_initiator: RTL and testbench
=====================================

TRDB_CFG_INITIATOR -- requirements
Module: trdb_cfg_initiator

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, peripheral address width.
REQ-002 SHALL have parameter POLL_MAX, default 255, maximum number of poll reads before timeout (1..255).
REQ-003 SHALL have parameter POLL_GAP, default 4, idle cycles between poll reads (1..15).
REQ-004 SHALL have clk_i  input  1  clock.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid_i, cmd_ready_o  in/out  1  command handshake.
REQ-007 SHALL have cmd_op_i  input  2  00 read, 01 write, 10 poll, 11 reserved.
REQ-008 SHALL have cmd_addr_i  input  APB_ADDR_WIDTH  target register address.
REQ-009 SHALL have cmd_wdata_i  input  32  write data.
REQ-010 SHALL have cmd_mask_i, cmd_expect_i  input  32 each  poll compare mask and expected value.
REQ-011 SHALL have rsp_valid_o, rsp_ready_i  out/in  1  response handshake.
REQ-012 SHALL have rsp_rdata_o  output  32  read or last poll data, 0 for writes.
REQ-013 SHALL have rsp_err_o  output  1  poll timeout or reserved op.
REQ-014 SHALL have rsp_attempts_o  output  8  poll reads issued (1 for read/write, 0 for reserved).
REQ-015 SHALL have per_valid_o, per_we_o  output  1 each; per_addr_o  output  APB_ADDR_WIDTH; per_wdata_o  output  32.
REQ-016 SHALL have per_ready_i  input  1; per_rdata_i  input  32, valid in the per_valid_o & per_ready_i cycle.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, GAP, RESP.
REQ-018 SHALL assert cmd_ready_o only in IDLE; command handshake latches all cmd_* fields.
REQ-019 IDLE on handshake: op 00/01/10 SHALL go ACCESS with attempt count 1; op 11 SHALL go RESP with err=1, rdata=0, attempts=0.
REQ-020 ACCESS SHALL drive per_valid_o=1 from registers; per_addr_o/per_wdata_o/per_we_o stable until per_ready_i; per_we_o=1 only for write.
REQ-021 ACCESS with per_ready_i=0 SHALL hold all per_* outputs indefinitely (no internal timeout).
REQ-022 Read/write completion SHALL capture per_rdata_i (read) or 0 (write) into rsp_rdata_o and go RESP, err=0.
REQ-023 Poll completion SHALL capture per_rdata_i; if (rdata & mask)==expect go RESP err=0; else if attempts==POLL_MAX go RESP err=1; else increment attempts and go GAP.
REQ-024 GAP SHALL deassert per_valid_o for exactly POLL_GAP cycles, then return to ACCESS.
REQ-025 RESP SHALL hold rsp_valid_o=1 and all rsp_* stable until rsp_ready_i; handshake returns to IDLE next cycle.
REQ-026 Latency: command accepted cycle T -> per_valid_o at T+1; if per_ready_i at T+1 -> rsp_valid_o at T+2.
REQ-027 Back-to-back: next command SHALL not be accepted earlier than the cycle after the response handshake.
REQ-028 per_valid_o and rsp_valid_o SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be driven from flops (no combinational path from inputs to outputs).
REQ-030 Mask 0 with expect 0 SHALL succeed on the first poll read; expect bits outside mask SHALL cause timeout.

Reset
REQ-031 Reset SHALL force IDLE; cmd_ready_o=1 after reset release; all other outputs 0.
REQ-032 Reset mid-ACCESS/GAP/RESP SHALL drop per_valid_o and rsp_valid_o asynchronously, discarding the command.

Structure
REQ-033 Op encoding SHALL be a typedef enum trdb_cfg_op_e in trdb_pkg; register addresses SHALL use existing trdb_pkg REG_TRDB_* constants.
REQ-034 SHALL be a single module with no sub-modules; FSM state typedef local to the module.

Verification
REQ-035 Write REG_TRDB_CTRL data 0x1, per_ready_i tied 1 -> one per_valid_o cycle, per_we_o=1, rsp rdata 0, err 0, attempts 1 at T+2.
REQ-036 Read REG_TRDB_STATUS, responder returns 0x5 -> rsp_rdata_o=0x5, err 0, attempts 1.
REQ-037 Poll REG_TRDB_CTRL mask 0x8 expect 0x0, flush bit clears after 3rd read -> three reads separated by POLL_GAP=4 idle cycles, rsp attempts 3, err 0.
REQ-038 Poll with POLL_MAX=5 never matching -> exactly 5 reads, rsp err 1, attempts 5, rdata = last read.
REQ-039 per_ready_i low 7 cycles, rsp_ready_i low 3 cycles -> per_* and rsp_* stable throughout, cmd_ready_o low until IDLE.
REQ-040 Reserved op 11 -> no per_valid_o, rsp err 1, attempts 0; reset asserted during GAP -> all valid outputs 0, next command accepted normally.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared trace-debugger definitions: register map and configuration-initiator
// command encoding.
package trdb_pkg;

    localparam logic [11:0] REG_TRDB_CTRL   = 12'h000;
    localparam logic [11:0] REG_TRDB_STATUS = 12'h004;
    localparam logic [11:0] REG_TRDB_FILTER = 12'h008;
    localparam logic [11:0] REG_TRDB_DUMP   = 12'h00C;

    typedef enum logic [1:0] {
        TRDB_OP_READ  = 2'b00,
        TRDB_OP_WRITE = 2'b01,
        TRDB_OP_POLL  = 2'b10,
        TRDB_OP_RSVD  = 2'b11
    } trdb_cfg_op_e;

    // A poll read succeeds when the masked read data equals the expected value;
    // expected bits outside the mask can therefore never match.
    function automatic logic poll_hit(input logic [31:0] rdata,
                                      input logic [31:0] mask,
                                      input logic [31:0] exp_val);
        return ((rdata & mask) == exp_val);
    endfunction

endpackage

// File: rtl/trdb_cfg_initiator.sv
// Command-driven register initiator: single read, single write, or polled read
// until a masked compare matches or the poll budget runs out.
module trdb_cfg_initiator
    import trdb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned POLL_MAX       = 255,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    input  logic [31:0]               cmd_mask_i,
    input  logic [31:0]               cmd_expect_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [7:0]                rsp_attempts_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic                      per_ready_i,
    input  logic [31:0]               per_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);
    localparam logic [3:0] GAP_LAST_C = 4'(POLL_GAP - 1);

    state_e                    state_r;
    trdb_cfg_op_e              op_r;
    logic [APB_ADDR_WIDTH-1:0] addr_r;
    logic [31:0]               wdata_r;
    logic [31:0]               mask_r;
    logic [31:0]               exp_r;
    logic [7:0]                attempts_r;
    logic [3:0]                gap_cnt_r;
    logic                      cmd_ready_r;
    logic                      per_valid_r;
    logic                      per_we_r;
    logic                      rsp_valid_r;
    logic [31:0]               rsp_rdata_r;
    logic                      rsp_err_r;

    // Control FSM; every output is a flop so no input reaches an output combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            op_r        <= TRDB_OP_READ;
            addr_r      <= '0;
            wdata_r     <= 32'd0;
            mask_r      <= 32'd0;
            exp_r       <= 32'd0;
            attempts_r  <= 8'd0;
            gap_cnt_r   <= 4'd0;
            cmd_ready_r <= 1'b1;
            per_valid_r <= 1'b0;
            per_we_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_r        <= trdb_cfg_op_e'(cmd_op_i);
                        addr_r      <= cmd_addr_i;
                        wdata_r     <= cmd_wdata_i;
                        mask_r      <= cmd_mask_i;
                        exp_r       <= cmd_expect_i;
                        cmd_ready_r <= 1'b0;
                        case (trdb_cfg_op_e'(cmd_op_i))
                            TRDB_OP_READ, TRDB_OP_WRITE, TRDB_OP_POLL: begin
                                state_r     <= ST_ACCESS;
                                per_valid_r <= 1'b1;
                                per_we_r    <= (cmd_op_i == TRDB_OP_WRITE);
                                attempts_r  <= 8'd1;
                            end
                            default: begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b1;
                                rsp_rdata_r <= 32'd0;
                                attempts_r  <= 8'd0;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    if (per_ready_i) begin
                        per_valid_r <= 1'b0;
                        per_we_r    <= 1'b0;
                        if (op_r == TRDB_OP_POLL) begin
                            rsp_rdata_r <= per_rdata_i;
                            if (poll_hit(per_rdata_i, mask_r, exp_r)) begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b0;
                            end else if (attempts_r == POLL_MAX_C) begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b1;
                            end else begin
                                state_r    <= ST_GAP;
                                attempts_r <= attempts_r + 8'd1;
                                gap_cnt_r  <= 4'd0;
                            end
                        end else begin
                            rsp_rdata_r <= (op_r == TRDB_OP_WRITE) ? 32'd0 : per_rdata_i;
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    // Re-raise valid on the last idle cycle so the bus sees exactly POLL_GAP idle cycles.
                    if (gap_cnt_r == GAP_LAST_C) begin
                        state_r     <= ST_ACCESS;
                        per_valid_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    per_valid_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o    = cmd_ready_r;
    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_rdata_o    = rsp_rdata_r;
    assign rsp_err_o      = rsp_err_r;
    assign rsp_attempts_o = attempts_r;
    assign per_valid_o    = per_valid_r;
    assign per_we_o       = per_we_r;
    assign per_addr_o     = addr_r;
    assign per_wdata_o    = wdata_r;

endmodule

// File: tb/tb_trdb_cfg_initiator.sv
// Directed bench for trdb_cfg_initiator with a table-driven register responder.
module tb_trdb_cfg_initiator;
    import trdb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [11:0] cmd_addr = 12'h000;
    logic [31:0] cmd_wdata = 32'd0;
    logic [31:0] cmd_mask = 32'd0;
    logic [31:0] cmd_exp = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  rsp_attempts;
    logic        per_valid;
    logic        per_we;
    logic [11:0] per_addr;
    logic [31:0] per_wdata;
    logic        per_ready = 1'b1;
    logic [31:0] per_rdata;

    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          base = 0;
    int          cyc = 0;
    int          overlap = 0;
    int          hs_cyc [0:63];
    logic [31:0] rdata_tab [0:7];
    logic [31:0] rd_idx;
    logic        ok;

    trdb_cfg_initiator #(.APB_ADDR_WIDTH(12), .POLL_MAX(5), .POLL_GAP(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
        .cmd_expect_i(cmd_exp),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_attempts_o(rsp_attempts),
        .per_valid_o(per_valid), .per_we_o(per_we), .per_addr_o(per_addr),
        .per_wdata_o(per_wdata), .per_ready_i(per_ready), .per_rdata_i(per_rdata)
    );

    always #5 clk = ~clk;

    assign rd_idx    = 32'(hs_cnt - base);
    assign per_rdata = rdata_tab[rd_idx[2:0]];

    // Responder bookkeeping: handshake count/timestamps and valid-overlap detector.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (per_valid && per_ready) begin
            hs_cyc[hs_cnt[5:0]] <= cyc;
            hs_cnt <= hs_cnt + 1;
        end
        if (per_valid && rsp_valid) overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] mk, input logic [31:0] ev);
        base      = hs_cnt;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_mask  = mk;
        cmd_exp   = ev;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cyc);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_arrives", 32'(rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rdata_tab[i] = 32'd0;
        // Reset state
        #2;
        chk("rst_per_valid", 32'(per_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_attempts", 32'(rsp_attempts), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);

        // Write CTRL = 0x1 with per_ready tied high
        per_ready = 1'b1;
        issue(2'b01, REG_TRDB_CTRL, 32'h1, 32'd0, 32'd0);
        chk("wr_per_valid_t1", 32'(per_valid), 32'd1);
        chk("wr_per_we", 32'(per_we), 32'd1);
        chk("wr_per_addr", 32'(per_addr), 32'(REG_TRDB_CTRL));
        chk("wr_per_wdata", per_wdata, 32'h1);
        chk("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("wr_rsp_valid_t2", 32'(rsp_valid), 32'd1);
        chk("wr_per_valid_off", 32'(per_valid), 32'd0);
        chk("wr_rdata", rsp_rdata, 32'd0);
        chk("wr_err", 32'(rsp_err), 32'd0);
        chk("wr_attempts", 32'(rsp_attempts), 32'd1);
        chk("wr_one_access", 32'(hs_cnt - base), 32'd1);
        finish_rsp();

        // Read STATUS returning 0x5
        rdata_tab[0] = 32'h5;
        issue(2'b00, REG_TRDB_STATUS, 32'hDEAD, 32'd0, 32'd0);
        chk("rd_per_we", 32'(per_we), 32'd0);
        chk("rd_per_addr", 32'(per_addr), 32'(REG_TRDB_STATUS));
        @(posedge clk); #1;
        chk("rd_rsp_valid_t2", 32'(rsp_valid), 32'd1);
        chk("rd_rdata", rsp_rdata, 32'h5);
        chk("rd_err", 32'(rsp_err), 32'd0);
        chk("rd_attempts", 32'(rsp_attempts), 32'd1);
        finish_rsp();

        // Poll CTRL flush bit (mask 0x8, expect 0) clearing on the third read
        rdata_tab[0] = 32'h9; rdata_tab[1] = 32'h8; rdata_tab[2] = 32'h1;
        issue(2'b10, REG_TRDB_CTRL, 32'd0, 32'h8, 32'h0);
        wait_rsp(100);
        chk("poll_reads", 32'(hs_cnt - base), 32'd3);
        chk("poll_gap1", 32'(hs_cyc[base + 1] - hs_cyc[base]), 32'd5);
        chk("poll_gap2", 32'(hs_cyc[base + 2] - hs_cyc[base + 1]), 32'd5);
        chk("poll_attempts", 32'(rsp_attempts), 32'd3);
        chk("poll_err", 32'(rsp_err), 32'd0);
        chk("poll_rdata", rsp_rdata, 32'h1);
        finish_rsp();

        // Poll that never matches: exactly POLL_MAX=5 reads, timeout
        for (int i = 0; i < 8; i++) rdata_tab[i] = 32'h11 + 32'(i);
        issue(2'b10, REG_TRDB_STATUS, 32'd0, 32'hF, 32'h0);
        wait_rsp(200);
        chk("tmo_reads", 32'(hs_cnt - base), 32'd5);
        chk("tmo_err", 32'(rsp_err), 32'd1);
        chk("tmo_attempts", 32'(rsp_attempts), 32'd5);
        chk("tmo_rdata_last", rsp_rdata, 32'h15);
        finish_rsp();

        // Mask 0 / expect 0 matches on the first read
        issue(2'b10, REG_TRDB_FILTER, 32'd0, 32'h0, 32'h0);
        wait_rsp(20);
        chk("m0_attempts", 32'(rsp_attempts), 32'd1);
        chk("m0_err", 32'(rsp_err), 32'd0);
        finish_rsp();

        // Expect bit outside mask can never match
        for (int i = 0; i < 8; i++) rdata_tab[i] = 32'hFFFF_FFFF;
        issue(2'b10, REG_TRDB_FILTER, 32'd0, 32'h1, 32'h2);
        wait_rsp(200);
        chk("om_attempts", 32'(rsp_attempts), 32'd5);
        chk("om_err", 32'(rsp_err), 32'd1);
        finish_rsp();

        // Stalls: per_ready low 7 cycles, then rsp_ready low 3 cycles
        rdata_tab[0] = 32'h77;
        per_ready = 1'b0;
        issue(2'b00, REG_TRDB_DUMP, 32'h1234, 32'd0, 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (!(per_valid === 1'b1 && per_addr === REG_TRDB_DUMP && per_we === 1'b0 &&
                  per_wdata === 32'h1234 && cmd_ready === 1'b0 && rsp_valid === 1'b0)) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("stall_per_stable", 32'(ok), 32'd1);
        chk("stall_no_access", 32'(hs_cnt - base), 32'd0);
        per_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (!(rsp_valid === 1'b1 && rsp_rdata === 32'h77 && rsp_err === 1'b0 &&
                  rsp_attempts === 8'd1 && cmd_ready === 1'b0 && per_valid === 1'b0)) ok = 1'b0;
        end
        chk("stall_rsp_stable", 32'(ok), 32'd1);
        finish_rsp();

        // Reserved op: direct error response, no bus access
        issue(2'b11, REG_TRDB_CTRL, 32'd0, 32'd0, 32'd0);
        chk("rsv_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsv_per_valid", 32'(per_valid), 32'd0);
        chk("rsv_err", 32'(rsp_err), 32'd1);
        chk("rsv_attempts", 32'(rsp_attempts), 32'd0);
        chk("rsv_rdata", rsp_rdata, 32'd0);
        chk("rsv_no_access", 32'(hs_cnt - base), 32'd0);
        // Reset mid-RESP drops rsp_valid asynchronously
        #3 rst_n = 1'b0;
        #1 chk("rst_resp_async", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset mid-ACCESS drops per_valid asynchronously
        per_ready = 1'b0;
        issue(2'b00, REG_TRDB_STATUS, 32'd0, 32'd0, 32'd0);
        chk("acc_per_valid", 32'(per_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk("rst_access_async", 32'(per_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        per_ready = 1'b1;

        // Reset during GAP discards the poll
        for (int i = 0; i < 8; i++) rdata_tab[i] = 32'h0;
        issue(2'b10, REG_TRDB_CTRL, 32'd0, 32'h1, 32'h1);
        @(posedge clk); #1;
        chk("gap_per_valid_low", 32'(per_valid), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("gap_rst_per_valid", 32'(per_valid), 32'd0);
        chk("gap_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("gap_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (per_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
        end
        chk("gap_cmd_discarded", 32'(ok), 32'd1);

        // Next command after reset proceeds normally
        issue(2'b01, REG_TRDB_DUMP, 32'hA5A5_0001, 32'd0, 32'd0);
        chk("post_per_valid", 32'(per_valid), 32'd1);
        chk("post_per_wdata", per_wdata, 32'hA5A5_0001);
        @(posedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_attempts", 32'(rsp_attempts), 32'd1);
        chk("post_err", 32'(rsp_err), 32'd0);
        finish_rsp();

        chk("no_valid_overlap", 32'(overlap), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
